// File: rtl/cdc_pace_fifo.sv
// -----------------------------------------------------------------------------
// cdc_pace_fifo
//
// Source-domain feeder for the handshake bus synchronizer. Bursty single-cycle
// write events are absorbed into a small FIFO and re-emitted as single-cycle
// pulses. Consecutive pulses are spaced at least gap_i+1 cycles apart, so a
// synchronizer that has no backpressure never sees a pulse while a transfer is
// still in flight.
//
// Ports:
//   clk             source-domain clock, rising edge
//   reset_i         asynchronous, active-high reset
//   in_valid        push strobe, one event per high cycle
//   in_data         data sampled with in_valid
//   gap_i           minimum idle cycles between output pulses, sampled at pop
//   flush_i         synchronous flush: empties FIFO, cancels the gap count
//   clr_overflow_i  clears the sticky overflow flag
//   out_pulse       one-cycle event to the synchronizer's src_pulse
//   out_data        data to the synchronizer's src_data, held between pulses
//   level_o         FIFO occupancy, 0..2**pDEPTH_LOG2
//   full_o          level_o == depth
//   empty_o         level_o == 0
//   overflow_o      sticky: an event arrived while full and was dropped
// -----------------------------------------------------------------------------
module cdc_pace_fifo #(
   parameter int pDATA_WIDTH = 8,
   parameter int pDEPTH_LOG2 = 3
) (
   input  logic                   clk,
   input  logic                   reset_i,
   input  logic                   in_valid,
   input  logic [pDATA_WIDTH-1:0] in_data,
   input  logic [7:0]             gap_i,
   input  logic                   flush_i,
   input  logic                   clr_overflow_i,
   output logic                   out_pulse,
   output logic [pDATA_WIDTH-1:0] out_data,
   output logic [pDEPTH_LOG2:0]   level_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic                   overflow_o
);

   localparam int DEPTH = 2 ** pDEPTH_LOG2;
   localparam logic [pDEPTH_LOG2:0]   LEVEL_FULL = (pDEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [pDEPTH_LOG2:0]   LEVEL_ONE  = (pDEPTH_LOG2 + 1)'(1);
   localparam logic [pDEPTH_LOG2-1:0] PTR_ONE    = pDEPTH_LOG2'(1);

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } pace_state_t;

   pace_state_t            state;
   logic [7:0]             gap_cnt;
   logic [pDATA_WIDTH-1:0] mem [DEPTH];
   logic [pDEPTH_LOG2-1:0] wr_ptr;
   logic [pDEPTH_LOG2-1:0] rd_ptr;
   logic [pDEPTH_LOG2:0]   level_nxt;

   logic push;
   logic pop;
   logic drop;

   // full_o/empty_o are the registered flags, so a pop in the same cycle does
   // not make room for a push that arrives while full.
   assign push = in_valid & ~full_o & ~flush_i;
   assign drop = in_valid &  full_o & ~flush_i;
   assign pop  = (state == ST_IDLE) & ~empty_o & ~flush_i;

   always_comb begin
      // NOTE: every variable assigned here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      level_nxt = level_o;
      if (flush_i) begin
         level_nxt = '0;
      end else if (push & ~pop) begin
         level_nxt = level_o + LEVEL_ONE;
      end else if (pop & ~push) begin
         level_nxt = level_o - LEVEL_ONE;
      end
   end

   // NOTE: the storage array has no reset; its contents are only ever read
   // behind a valid level count, so resetting it would buy nothing.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // Pointers, occupancy and the derived flags.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         // NOTE: sequential state is updated only with non-blocking
         // assignments so every register samples pre-edge values.
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_o <= '0;
         full_o  <= 1'b0;
         empty_o <= 1'b1;
      end else begin
         if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         end
         level_o <= level_nxt;
         full_o  <= (level_nxt == LEVEL_FULL);
         empty_o <= (level_nxt == '0);
      end
   end

   // Sticky overflow; a drop in the same cycle as a clear wins. A flush
   // leaves the flag alone.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         overflow_o <= 1'b0;
      end else if (drop) begin
         overflow_o <= 1'b1;
      end else if (clr_overflow_i) begin
         overflow_o <= 1'b0;
      end
   end

   // Pacer. A pop loads gap_cnt from gap_i; WAIT counts it down to zero before
   // the next pop is allowed, so pulses are at least gap_i+1 cycles apart.
   // gap_i is only looked at on the pop edge.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         state     <= ST_IDLE;
         gap_cnt   <= '0;
         out_pulse <= 1'b0;
         out_data  <= '0;
      end else if (flush_i) begin
         state     <= ST_IDLE;
         gap_cnt   <= '0;
         out_pulse <= 1'b0;
      end else begin
         out_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  out_pulse <= 1'b1;
                  out_data  <= mem[rd_ptr];
                  gap_cnt   <= gap_i;
                  state     <= (gap_i != 8'd0) ? ST_WAIT : ST_IDLE;
               end
            end
            ST_WAIT: begin
               gap_cnt <= gap_cnt - 8'd1;
               if (gap_cnt == 8'd1) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cdc_pace_fifo.sv
// -----------------------------------------------------------------------------
// tb_cdc_pace_fifo
//
// Directed bench for cdc_pace_fifo (pDATA_WIDTH = 8, depth 8). Stimulus pushes
// the data it expects to see emitted into a scoreboard queue; an independent
// monitor pops and compares whenever out_pulse is high and records the cycle
// of every pulse so that spacing can be checked afterwards.
// -----------------------------------------------------------------------------
module tb_cdc_pace_fifo;

   localparam int DW = 8;
   localparam int DL = 3;

   logic          clk            = 1'b0;
   logic          reset_i        = 1'b1;
   logic          in_valid       = 1'b0;
   logic [DW-1:0] in_data        = '0;
   logic [7:0]    gap_i          = '0;
   logic          flush_i        = 1'b0;
   logic          clr_overflow_i = 1'b0;
   logic          out_pulse;
   logic [DW-1:0] out_data;
   logic [DL:0]   level_o;
   logic          full_o;
   logic          empty_o;
   logic          overflow_o;

   int            n_cmp = 0;
   int            n_err = 0;
   int            cyc   = 0;
   logic [DW-1:0] exp_q[$];
   int            pulse_t[$];

   cdc_pace_fifo #(
      .pDATA_WIDTH (DW),
      .pDEPTH_LOG2 (DL)
   ) dut (
      .clk            (clk),
      .reset_i        (reset_i),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .gap_i          (gap_i),
      .flush_i        (flush_i),
      .clr_overflow_i (clr_overflow_i),
      .out_pulse      (out_pulse),
      .out_data       (out_data),
      .level_o        (level_o),
      .full_o         (full_o),
      .empty_o        (empty_o),
      .overflow_o     (overflow_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Monitor: every pulse must carry the oldest outstanding expected value.
   always begin
      @(posedge clk);
      #1;
      if (out_pulse === 1'b1) begin
         pulse_t.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_pulse: actual data %0h with no event outstanding", out_data);
         end else begin
            check("out_data", out_data, exp_q.pop_front());
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_push(input logic [DW-1:0] d, input bit accepted);
      in_valid = 1'b1;
      in_data  = d;
      if (accepted) exp_q.push_back(d);
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      in_valid = 1'b0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      check({name, "_drained"}, exp_q.size(), 0);
      step(2);
      check({name, "_empty"}, empty_o, 1'b1);
      check({name, "_level"}, level_o, 0);
   endtask

   task automatic check_reset_values(input string name);
      check({name, "_pulse"},    out_pulse,  1'b0);
      check({name, "_data"},     out_data,   8'h00);
      check({name, "_level"},    level_o,    0);
      check({name, "_empty"},    empty_o,    1'b1);
      check({name, "_full"},     full_o,     1'b0);
      check({name, "_overflow"}, overflow_o, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int k;
      logic [DL:0] burst_lvl [5];
      burst_lvl[0] = 4'd1;
      burst_lvl[1] = 4'd1;
      burst_lvl[2] = 4'd2;
      burst_lvl[3] = 4'd3;
      burst_lvl[4] = 4'd4;

      // ---------------- reset and single event ----------------
      step(3);
      check_reset_values("reset");
      reset_i = 1'b0;
      step();

      gap_i = 8'd4;
      drive_push(8'hA5, 1'b1);
      step();
      in_valid = 1'b0;
      check("single_level_after_push", level_o, 1);
      check("single_not_empty", empty_o, 1'b0);
      check("single_no_early_pulse", out_pulse, 1'b0);
      step();
      check("single_pulse", out_pulse, 1'b1);
      check("single_data", out_data, 8'hA5);
      check("single_level_after_pop", level_o, 0);
      step();
      check("single_pulse_one_cycle", out_pulse, 1'b0);
      check("single_data_held", out_data, 8'hA5);
      step(6);

      // ---------------- burst with spacing ----------------
      base = pulse_t.size();
      for (int i = 0; i < 5; i++) begin
         drive_push(8'(i + 1), 1'b1);
         step();
         check("burst_level", level_o, burst_lvl[i]);
      end
      drain("burst", 60);
      check("burst_pulse_count", pulse_t.size() - base, 5);
      for (int i = base + 1; i < pulse_t.size(); i++)
         check("burst_spacing", pulse_t[i] - pulse_t[i-1], 5);
      step(6);

      // ---------------- zero gap ----------------
      gap_i = 8'd0;
      base  = pulse_t.size();
      for (int i = 0; i < 12; i++) begin
         drive_push(8'h20 + 8'(i), 1'b1);
         step();
      end
      drain("zero_gap", 40);
      check("zero_gap_pulse_count", pulse_t.size() - base, 12);
      for (int i = base + 1; i < pulse_t.size(); i++)
         check("zero_gap_spacing", pulse_t[i] - pulse_t[i-1], 1);
      check("zero_gap_no_overflow", overflow_o, 1'b0);

      // ---------------- overflow while pacer waits ----------------
      base  = pulse_t.size();
      gap_i = 8'd255;
      drive_push(8'hE0, 1'b1);
      step();
      in_valid = 1'b0;
      step();
      check("ovf_hold_pulse", out_pulse, 1'b1);
      gap_i = 8'd0;  // must not shorten the wait already in progress
      for (int i = 0; i < 10; i++) begin
         drive_push(8'hB0 + 8'(i), i < 8);
         step();
      end
      check("ovf_level", level_o, 8);
      check("ovf_full", full_o, 1'b1);
      check("ovf_flag_set", overflow_o, 1'b1);
      drive_push(8'hBF, 1'b0);
      clr_overflow_i = 1'b1;
      step();
      in_valid = 1'b0;
      check("ovf_set_beats_clear", overflow_o, 1'b1);
      check("ovf_level_unchanged", level_o, 8);
      step();
      clr_overflow_i = 1'b0;
      check("ovf_cleared", overflow_o, 1'b0);
      drain("overflow", 400);
      check("ovf_pulse_count", pulse_t.size() - base, 9);
      if (pulse_t.size() - base == 9) begin
         check("ovf_long_gap", pulse_t[base+1] - pulse_t[base], 256);
         for (int i = base + 2; i < pulse_t.size(); i++)
            check("ovf_drain_spacing", pulse_t[i] - pulse_t[i-1], 1);
      end

      // ---------------- pointer wrap-around ----------------
      gap_i = 8'd1;
      base  = pulse_t.size();
      k     = 0;
      for (int i = 0; i < 36; i++) begin
         if (i % 3 != 2) begin
            drive_push(8'h40 + 8'(k), 1'b1);
            k++;
         end else begin
            in_valid = 1'b0;
         end
         step();
         check("wrap_level_bound", level_o > 4'd8, 1'b0);
      end
      drain("wrap", 100);
      check("wrap_pulse_count", pulse_t.size() - base, 24);

      // ---------------- flush mid-WAIT ----------------
      gap_i = 8'd20;
      step(2);
      base = pulse_t.size();
      for (int i = 0; i < 6; i++) begin
         drive_push(8'h60 + 8'(i), 1'b1);
         step();
      end
      in_valid = 1'b0;
      flush_i  = 1'b1;
      exp_q.delete();  // queued entries are discarded by the flush
      step();
      flush_i = 1'b0;
      check("flush_level", level_o, 0);
      check("flush_empty", empty_o, 1'b1);
      check("flush_no_pulse", out_pulse, 1'b0);
      check("flush_data_held", out_data, 8'h60);
      gap_i = 8'd3;
      drive_push(8'h77, 1'b1);
      step();
      in_valid = 1'b0;
      check("after_flush_no_early_pulse", out_pulse, 1'b0);
      step();
      check("after_flush_pulse", out_pulse, 1'b1);
      check("after_flush_data", out_data, 8'h77);
      drain("flush", 10);
      check("flush_pulse_count", pulse_t.size() - base, 2);
      step(4);

      // ---------------- asynchronous reset mid-burst ----------------
      gap_i = 8'd2;
      for (int i = 0; i < 4; i++) begin
         drive_push(8'h90 + 8'(i), 1'b1);
         step();
      end
      in_valid = 1'b0;
      step();
      check("midrst_pulse_before", out_pulse, 1'b1);
      check("midrst_data_before", out_data, 8'h91);
      check("midrst_level_before", level_o, 2);
      #2;
      reset_i = 1'b1;
      exp_q.delete();
      #1;
      check_reset_values("async_reset");
      step(2);
      reset_i = 1'b0;
      step();
      base = pulse_t.size();
      drive_push(8'h3C, 1'b1);
      step();
      in_valid = 1'b0;
      step();
      check("post_reset_pulse", out_pulse, 1'b1);
      check("post_reset_data", out_data, 8'h3C);
      step();
      check("post_reset_pulse_one_cycle", out_pulse, 1'b0);
      drain("post_reset", 10);
      check("post_reset_pulse_count", pulse_t.size() - base, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
